// File: rtl/tbird_signal_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tbird_signal_ctrl
//  Purpose  : Front end for the T-bird taillight sequencer. Synchronises and
//             debounces the left lever, right lever and hazard button, then
//             arbitrates them into one mutually exclusive request. Generates
//             the slow step strobe that clocks the lights FSM, and a one-cycle
//             restart pulse whenever the requested mode changes.
//
//  Ports    : clk          in   system clock
//             rst          in   asynchronous, active-high reset
//             left_raw     in   raw left lever (asynchronous)
//             right_raw    in   raw right lever (asynchronous)
//             haz_btn_raw  in   raw hazard push button (asynchronous)
//             left_req     out  left sequence requested
//             right_req    out  right sequence requested
//             haz_req      out  hazard flashing requested
//             step         out  one-cycle advance strobe for the lights FSM
//             restart      out  one-cycle pulse on every mode change
//             conflict     out  both levers held while idle
//
//  Parameters: DIV          step period in clk cycles (>= 2)
//              DEB_CYCLES   stable synced cycles needed to accept a change (>= 1)
//              CANCEL_STEPS steps before a turn request auto-cancels
//
//  Build option: define AUTO_CANCEL_EN to auto-cancel a turn request after
//                CANCEL_STEPS steps and lock that lever out until released.
//
//  Revision : 1.0  initial release
// ============================================================================
module tbird_signal_ctrl #(
    parameter int DIV          = 16,
    parameter int DEB_CYCLES   = 3,
    parameter int CANCEL_STEPS = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic left_raw,
    input  logic right_raw,
    input  logic haz_btn_raw,
    output logic left_req,
    output logic right_req,
    output logic haz_req,
    output logic step,
    output logic restart,
    output logic conflict
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int C_PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int C_DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    localparam logic [C_PW-1:0] C_PRE_MAX = C_PW'(DIV - 1);
    localparam logic [C_DW-1:0] C_DEB_MAX = C_DW'(DEB_CYCLES - 1);

    // Bit positions of the three inputs in the packed raw/debounced vectors
    localparam int C_IN_LEFT  = 0;
    localparam int C_IN_RIGHT = 1;
    localparam int C_IN_HAZ   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2,
        ST_HAZ   = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [2:0]      w_raw;
    logic [2:0]      w_db;

    logic            r_haz_db_q;
    logic            r_haz_on;

    state_t          r_state;
    state_t          r_state_q;
    state_t          w_next;

    logic [C_PW-1:0] r_pre;
    logic            w_restart;
    logic            w_step;
    logic            r_conflict;

    logic            w_lock_l;
    logic            w_lock_r;
    logic            w_cancel_l;
    logic            w_cancel_r;

    assign w_raw = {haz_btn_raw, right_raw, left_raw};

    // ------------------------------------------------------------------------
    // Per-input 2-flop synchroniser followed by a debounce counter.
    // The counter only runs while the synced value disagrees with the
    // accepted value; any agreement in between restarts it, so a pulse
    // must persist for DEB_CYCLES consecutive synced cycles to be accepted.
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_deb
            logic            r_s1;
            logic            r_s2;
            logic            r_db;
            logic [C_DW-1:0] r_cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_s1  <= 1'b0;
                    r_s2  <= 1'b0;
                    r_db  <= 1'b0;
                    r_cnt <= '0;
                end else begin
                    r_s1 <= w_raw[gi];
                    r_s2 <= r_s1;
                    if (r_s2 == r_db) begin
                        r_cnt <= '0;
                    end else if (r_cnt == C_DEB_MAX) begin
                        r_db  <= r_s2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + C_DW'(1);
                    end
                end
            end

            assign w_db[gi] = r_db;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Hazard toggle: flips once per debounced press; release does nothing.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_haz_db_q <= 1'b0;
            r_haz_on   <= 1'b0;
        end else begin
            r_haz_db_q <= w_db[C_IN_HAZ];
            r_haz_on   <= r_haz_on ^ (w_db[C_IN_HAZ] & ~r_haz_db_q);
        end
    end

    // ------------------------------------------------------------------------
    // Mode FSM: state register plus previous-state copy for restart.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_state_q <= ST_IDLE;
        end else begin
            r_state   <= w_next;
            r_state_q <= r_state;
        end
    end

    // Next state and Moore request decode. A turn direction, once taken,
    // is held until its own lever drops; the other lever is ignored, so a
    // direction change always passes through IDLE.
    always_comb begin
        w_next    = r_state;
        left_req  = 1'b0;
        right_req = 1'b0;
        haz_req   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_haz_on) begin
                    w_next = ST_HAZ;
                end else if (w_db[C_IN_LEFT] & ~w_db[C_IN_RIGHT] & ~w_lock_l) begin
                    w_next = ST_LEFT;
                end else if (w_db[C_IN_RIGHT] & ~w_db[C_IN_LEFT] & ~w_lock_r) begin
                    w_next = ST_RIGHT;
                end
            end
            ST_LEFT: begin
                left_req = 1'b1;
                if (r_haz_on) begin
                    w_next = ST_HAZ;
                end else if (~w_db[C_IN_LEFT] | w_cancel_l) begin
                    w_next = ST_IDLE;
                end
            end
            ST_RIGHT: begin
                right_req = 1'b1;
                if (r_haz_on) begin
                    w_next = ST_HAZ;
                end else if (~w_db[C_IN_RIGHT] | w_cancel_r) begin
                    w_next = ST_IDLE;
                end
            end
            ST_HAZ: begin
                haz_req = 1'b1;
                if (~r_haz_on) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Restart marks the first cycle spent in a newly entered state.
    assign w_restart = (r_state != r_state_q);
    assign restart   = w_restart;

    // ------------------------------------------------------------------------
    // Step prescaler. Cleared while idle and in the restart cycle so the
    // first step of a mode lands exactly DIV cycles after entry. The
    // restart term in the strobe covers the case where the counter happened
    // to sit at its terminal value when the mode changed.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
        end else if ((r_state == ST_IDLE) || w_restart) begin
            r_pre <= '0;
        end else if (r_pre == C_PRE_MAX) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + C_PW'(1);
        end
    end

    assign w_step = (r_state != ST_IDLE) & (r_pre == C_PRE_MAX) & ~w_restart;
    assign step   = w_step;

    // ------------------------------------------------------------------------
    // Conflict flag. Registered, then masked by the current state so it can
    // never be seen outside IDLE, even in the cycle after leaving IDLE.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_conflict <= 1'b0;
        end else begin
            r_conflict <= (r_state == ST_IDLE) & w_db[C_IN_LEFT] & w_db[C_IN_RIGHT];
        end
    end

    assign conflict = r_conflict & (r_state == ST_IDLE);

`ifdef AUTO_CANCEL_EN
    // ------------------------------------------------------------------------
    // Turn auto-cancel: count steps in LEFT/RIGHT; the CANCEL_STEPS-th step
    // returns to IDLE and locks that lever until its debounced value falls.
    // Hazard and lever release take priority over the cancel.
    // ------------------------------------------------------------------------
    localparam int C_SW = (CANCEL_STEPS > 1) ? $clog2(CANCEL_STEPS) : 1;
    localparam logic [C_SW-1:0] C_CANCEL_MAX = C_SW'(CANCEL_STEPS - 1);

    logic [C_SW-1:0] r_scnt;
    logic            r_lock_l;
    logic            r_lock_r;
    logic            w_cancel_hit;
    logic            w_turning;

    assign w_turning    = (r_state == ST_LEFT) || (r_state == ST_RIGHT);
    assign w_cancel_hit = w_step & (r_scnt == C_CANCEL_MAX) & ~r_haz_on;
    assign w_cancel_l   = (r_state == ST_LEFT)  & w_db[C_IN_LEFT]  & w_cancel_hit;
    assign w_cancel_r   = (r_state == ST_RIGHT) & w_db[C_IN_RIGHT] & w_cancel_hit;
    assign w_lock_l     = r_lock_l;
    assign w_lock_r     = r_lock_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scnt <= '0;
        end else if (w_restart || !w_turning) begin
            r_scnt <= '0;
        end else if (w_step) begin
            r_scnt <= r_scnt + C_SW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock_l <= 1'b0;
            r_lock_r <= 1'b0;
        end else begin
            if (w_cancel_l) begin
                r_lock_l <= 1'b1;
            end else if (~w_db[C_IN_LEFT]) begin
                r_lock_l <= 1'b0;
            end
            if (w_cancel_r) begin
                r_lock_r <= 1'b1;
            end else if (~w_db[C_IN_RIGHT]) begin
                r_lock_r <= 1'b0;
            end
        end
    end
`else
    // Without auto-cancel a turn request persists while its lever is held.
    // CANCEL_STEPS has no effect; it is only referenced here so the plain
    // build keeps the same parameter list without an unused-parameter note.
    logic w_unused_cancel_steps;
    assign w_unused_cancel_steps = (CANCEL_STEPS > 0);

    assign w_cancel_l = 1'b0;
    assign w_cancel_r = 1'b0;
    assign w_lock_l   = 1'b0;
    assign w_lock_r   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tbird_signal_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tbird_signal_ctrl
//  Purpose  : Self-checking bench for tbird_signal_ctrl. Directed sequences
//             for the main scenarios followed by randomised lever/hazard
//             activity, every cycle compared against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tbird_signal_ctrl;

    localparam int DIV    = 4;
    localparam int DEB    = 3;
    localparam int CSTEPS = 3;

    localparam int M_IDLE  = 0;
    localparam int M_LEFT  = 1;
    localparam int M_RIGHT = 2;
    localparam int M_HAZ   = 3;
    localparam int HL      = 16;

`ifdef AUTO_CANCEL_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic left_raw = 1'b0;
    logic right_raw = 1'b0;
    logic haz_btn_raw = 1'b0;
    logic left_req, right_req, haz_req, step, restart, conflict;

    int n_vec = 0;
    int n_bad = 0;

    tbird_signal_ctrl #(
        .DIV          (DIV),
        .DEB_CYCLES   (DEB),
        .CANCEL_STEPS (CSTEPS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .left_raw    (left_raw),
        .right_raw   (right_raw),
        .haz_btn_raw (haz_btn_raw),
        .left_req    (left_req),
        .right_req   (right_req),
        .haz_req     (haz_req),
        .step        (step),
        .restart     (restart),
        .conflict    (conflict)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Behavioural model. Debounce is a sliding window over the raw history,
    // step timing is "cycles since the mode was entered" modulo DIV, and
    // auto-cancel fires once that age reaches CSTEPS * DIV.
    // ------------------------------------------------------------------------
    bit hist [3][HL];   // hist[j][d]: raw input j as seen before edge n-d
    bit m_db [3];
    bit m_hdb_pp;
    bit m_hon;
    int m_st;
    int m_age;
    bit m_lockl, m_lockr;
    bit e_left, e_right, e_haz, e_step, e_restart, e_conflict;

    function automatic void model_reset();
        for (int j = 0; j < 3; j++) begin
            for (int d = 0; d < HL; d++) hist[j][d] = 1'b0;
            m_db[j] = 1'b0;
        end
        m_hdb_pp   = 1'b0;
        m_hon      = 1'b0;
        m_st       = M_IDLE;
        m_age      = 0;
        m_lockl    = 1'b0;
        m_lockr    = 1'b0;
        e_left     = 1'b0;
        e_right    = 1'b0;
        e_haz      = 1'b0;
        e_step     = 1'b0;
        e_restart  = 1'b0;
        e_conflict = 1'b0;
    endfunction

    // Advance the model by one clock edge using the raw values present at it.
    function automatic void model_edge(input bit l, input bit r, input bit h);
        int st_p   = m_st;
        int age_p  = m_age;
        bit ldb_p  = m_db[0];
        bit rdb_p  = m_db[1];
        bit hdb_p  = m_db[2];
        bit hon_p  = m_hon;
        bit lockl_p = m_lockl;
        bit lockr_p = m_lockr;
        bit cancel = 1'b0;
        bit [2:0] raw_now = {h, r, l};

        for (int j = 0; j < 3; j++) begin
            for (int d = HL - 1; d > 0; d--) hist[j][d] = hist[j][d-1];
            hist[j][0] = raw_now[j];
        end
        // Two synchroniser edges, then DEB consecutive disagreeing samples.
        for (int j = 0; j < 3; j++) begin
            bit flip = 1'b1;
            for (int m = 0; m < DEB; m++) begin
                if (hist[j][2+m] == m_db[j]) flip = 1'b0;
            end
            if (flip) m_db[j] = ~m_db[j];
        end

        m_hon    = hon_p ^ (hdb_p & ~m_hdb_pp);
        m_hdb_pp = hdb_p;

        case (st_p)
            M_IDLE: begin
                if (hon_p) m_st = M_HAZ;
                else if (ldb_p && !rdb_p && !lockl_p) m_st = M_LEFT;
                else if (rdb_p && !ldb_p && !lockr_p) m_st = M_RIGHT;
            end
            M_LEFT: begin
                if (hon_p) m_st = M_HAZ;
                else if (!ldb_p) m_st = M_IDLE;
                else if (AUTO && age_p == CSTEPS * DIV) begin
                    m_st = M_IDLE;
                    cancel = 1'b1;
                end
            end
            M_RIGHT: begin
                if (hon_p) m_st = M_HAZ;
                else if (!rdb_p) m_st = M_IDLE;
                else if (AUTO && age_p == CSTEPS * DIV) begin
                    m_st = M_IDLE;
                    cancel = 1'b1;
                end
            end
            default: begin
                if (!hon_p) m_st = M_IDLE;
            end
        endcase

        if (cancel && st_p == M_LEFT) m_lockl = 1'b1;
        else if (!ldb_p)              m_lockl = 1'b0;
        if (cancel && st_p == M_RIGHT) m_lockr = 1'b1;
        else if (!rdb_p)               m_lockr = 1'b0;

        e_restart  = (m_st != st_p);
        m_age      = e_restart ? 0 : age_p + 1;
        e_step     = (m_st != M_IDLE) && !e_restart && (m_age % DIV == 0);
        e_left     = (m_st == M_LEFT);
        e_right    = (m_st == M_RIGHT);
        e_haz      = (m_st == M_HAZ);
        e_conflict = (m_st == M_IDLE) && (st_p == M_IDLE) && ldb_p && rdb_p;
    endfunction

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    task automatic chk(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    task automatic check_all();
        chk("left_req",  left_req,  e_left);
        chk("right_req", right_req, e_right);
        chk("haz_req",   haz_req,   e_haz);
        chk("step",      step,      e_step);
        chk("restart",   restart,   e_restart);
        chk("conflict",  conflict,  e_conflict);
    endtask

    // One clock with the current raw inputs, then compare.
    task automatic tick();
        @(posedge clk);
        #1;
        model_edge(left_raw, right_raw, haz_btn_raw);
        check_all();
    endtask

    task automatic hold(input bit l, input bit r, input bit h, input int cyc);
        left_raw    = l;
        right_raw   = r;
        haz_btn_raw = h;
        for (int i = 0; i < cyc; i++) tick();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic do_reset(input int cyc);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        for (int i = 0; i < cyc; i++) begin
            @(posedge clk);
            #1;
            check_all();
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        bit l, r, h;
        int len;

        // Reset with the left lever already up, then run into LEFT.
        left_raw = 1'b1;
        do_reset(3);
        hold(1, 0, 0, 20);

        // Debounce boundaries: 2-cycle glitch ignored, 3 accepted, 5 accepted.
        hold(0, 0, 0, 12);
        hold(1, 0, 0, 2);
        hold(0, 0, 0, 10);
        hold(1, 0, 0, 3);
        hold(0, 0, 0, 12);
        hold(1, 0, 0, 5);
        hold(0, 0, 0, 15);

        // Hazard overrides LEFT; second press returns to IDLE.
        hold(1, 0, 0, 15);
        hold(1, 0, 1, 10);
        hold(1, 0, 0, 12);
        hold(0, 0, 0, 12);
        hold(0, 0, 1, 10);
        hold(0, 0, 0, 15);

        // Both levers together: conflict, then drop right to enter LEFT.
        hold(1, 1, 0, 15);
        hold(1, 0, 0, 15);
        hold(0, 0, 0, 12);

        // Direction lock, then release left to fall through IDLE to RIGHT.
        hold(1, 0, 0, 12);
        hold(1, 1, 0, 12);
        hold(0, 1, 0, 15);
        hold(0, 0, 0, 12);

        // Long hold (auto-cancel when enabled), re-press, hazard while held.
        hold(1, 0, 0, 30);
        hold(0, 0, 0, 8);
        hold(1, 0, 0, 25);
        hold(1, 0, 1, 10);
        hold(1, 0, 0, 12);
        hold(1, 0, 1, 8);
        hold(0, 0, 0, 15);

        // Reset in the middle of a sequence.
        hold(0, 1, 0, 14);
        do_reset(2);
        hold(0, 1, 0, 12);
        hold(0, 0, 0, 10);

        // Randomised lever and button activity.
        for (int seg = 0; seg < 300; seg++) begin
            l = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                bit t = l;
                l = r;
                r = t;
            end
            h = ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0;
            if (h)                              len = $urandom_range(1, 10);
            else if ($urandom_range(0, 9) < 4)  len = $urandom_range(1, 4);
            else                                len = $urandom_range(5, 30);
            hold(l, r, h, len);
            if ($urandom_range(0, 49) == 0) do_reset(1);
        end
        hold(0, 0, 0, 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
